// File: rtl/rf_pkg.sv
// Shared register-file types and constants, common to the ROB, the retire
// scheduler and the architectural register file.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Dual-push / dual-pop circular write-back buffer. Entries are exposed in age
// order (index 0 = head) so that the ports and the forwarding search can use them.
module rf_wb_fifo #(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = 32,
  parameter int  AW    = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  push_cnt,
  input  logic [AW-1:0]               push_rd0,
  input  logic [XLEN-1:0]             push_data0,
  input  logic [AW-1:0]               push_rd1,
  input  logic [XLEN-1:0]             push_data1,
  input  logic [1:0]                  pop_cnt,
  output logic [CW-1:0]               count,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][AW-1:0]    ent_rd,
  output logic [DEPTH-1:0][XLEN-1:0]  ent_data
);
  // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
  logic [CW-1:0]              wptr, rptr;
  logic [PW-1:0]              widx0, widx1;
  logic [DEPTH-1:0][AW-1:0]   mem_rd;
  logic [DEPTH-1:0][XLEN-1:0] mem_data;

  assign widx0 = wptr[PW-1:0];
  assign widx1 = widx0 + 1'b1;
  assign count = wptr - rptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + CW'(push_cnt);
      rptr <= rptr + CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      mem_rd[widx0]   <= push_rd0;
      mem_data[widx0] <= push_data0;
    end
    if (push_cnt == 2'd2) begin
      mem_rd[widx1]   <= push_rd1;
      mem_data[widx1] <= push_data1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    logic [PW-1:0] idx;
    assign idx          = rptr[PW-1:0] + PW'(g);
    assign ent_valid[g] = CW'(g) < count;
    assign ent_rd[g]    = mem_rd[idx];
    assign ent_data[g]  = mem_data[idx];
  end
endmodule

// File: rtl/rf_retire_scheduler.sv
// Buffers up to two retirements per cycle and drains them in order onto the two
// RF write ports, suppressing same-rd collisions and forwarding pending values.
module rf_retire_scheduler #(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = rf_pkg::XLEN,
  parameter int  AW    = rf_pkg::AW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in0_valid,
  input  logic [AW-1:0]   in0_rd,
  input  logic [XLEN-1:0] in0_data,
  input  logic            in1_valid,
  input  logic [AW-1:0]   in1_rd,
  input  logic [XLEN-1:0] in1_data,
  output logic            in_ready,
  output logic [AW-1:0]   rd1,
  output logic [XLEN-1:0] rd1_data,
  output logic            regWrite1,
  output logic [AW-1:0]   rd2,
  output logic [XLEN-1:0] rd2_data,
  output logic            regWrite2,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic [CW-1:0]   count
);
  import rf_pkg::*;

  logic                       keep0, keep1, port1, port2, waw;
  logic [1:0]                 push_cnt, pop_cnt;
  logic [AW-1:0]              prd0;
  logic [XLEN-1:0]            pdata0;
  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0][AW-1:0]   ent_rd;
  logic [DEPTH-1:0][XLEN-1:0] ent_data;
  logic [1:0][AW-1:0]         rs_l;
  logic [1:0]                 hit_l;
  logic [1:0][XLEN-1:0]       fdata_l;

  // Credit comes only from the registered occupancy; a same-cycle drain is not counted.
  assign in_ready = (DEPTH - int'(count)) >= 2;

  // Compact the two slots: x0 or invalid slots leave no hole in the queue.
  assign keep0    = in0_valid && (in0_rd != AW'(ZERO_REG));
  assign keep1    = in1_valid && (in1_rd != AW'(ZERO_REG));
  assign push_cnt = in_ready ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;
  assign prd0     = keep0 ? in0_rd   : in1_rd;
  assign pdata0   = keep0 ? in0_data : in1_data;

  assign pop_cnt  = (count >= CW'(2)) ? 2'd2 : ((count != '0) ? 2'd1 : 2'd0);

  rf_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_cnt   (push_cnt),
    .push_rd0   (prd0),
    .push_data0 (pdata0),
    .push_rd1   (in1_rd),
    .push_data1 (in1_data),
    .pop_cnt    (pop_cnt),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd),
    .ent_data   (ent_data)
  );

  assign port1     = ent_valid[0];
  assign port2     = ent_valid[1];
  // Older write would be overwritten by the younger one in the same cycle anyway.
  assign waw       = port2 && (ent_rd[0] == ent_rd[1]);
  assign regWrite1 = port1 && !waw;
  assign regWrite2 = port2;
  assign rd1       = port1 ? ent_rd[0]   : '0;
  assign rd1_data  = port1 ? ent_data[0] : '0;
  assign rd2       = port2 ? ent_rd[1]   : '0;
  assign rd2_data  = port2 ? ent_data[1] : '0;

  assign rs_l = {rs2, rs1};

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit_l   = '0;
    fdata_l = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (rs_l[p] != AW'(ZERO_REG)) && (ent_rd[i] == rs_l[p])) begin
          hit_l[p]   = 1'b1;
          fdata_l[p] = ent_data[i];
        end
      end
    end
  end

  assign fwd1_hit  = hit_l[0];
  assign fwd2_hit  = hit_l[1];
  assign fwd1_data = fdata_l[0];
  assign fwd2_data = fdata_l[1];
endmodule

// File: tb/tb_rf_retire_scheduler.sv
// Drives a DEPTH=4 and a DEPTH=2 scheduler with the same retire stream and
// checks both against a queue-based model of the retire/drain/forward rules.
module tb_rf_retire_scheduler;
  import rf_pkg::*;

  logic clk, reset_n;
  logic in0_valid, in1_valid;
  logic [4:0] in0_rd, in1_rd, rs1, rs2;
  logic [31:0] in0_data, in1_data;

  logic [1:0] in_ready_o, rw1_o, rw2_o, h1_o, h2_o;
  logic [1:0][4:0] rd1_o, rd2_o;
  logic [1:0][31:0] d1_o, d2_o, f1_o, f2_o;
  logic [2:0] cnt4;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;
  int mdepth [2] = '{4, 2};
  rf_wr_t mq [2][$];
  logic [31:0] rf_exp [2][32];
  logic [31:0] rf_obs [2][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rf_retire_scheduler #(.DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data),
    .in_ready(in_ready_o[0]),
    .rd1(rd1_o[0]), .rd1_data(d1_o[0]), .regWrite1(rw1_o[0]),
    .rd2(rd2_o[0]), .rd2_data(d2_o[0]), .regWrite2(rw2_o[0]),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(h1_o[0]), .fwd2_hit(h2_o[0]),
    .fwd1_data(f1_o[0]), .fwd2_data(f2_o[0]),
    .count(cnt4)
  );

  rf_retire_scheduler #(.DEPTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data),
    .in_ready(in_ready_o[1]),
    .rd1(rd1_o[1]), .rd1_data(d1_o[1]), .regWrite1(rw1_o[1]),
    .rd2(rd2_o[1]), .rd2_data(d2_o[1]), .regWrite2(rw2_o[1]),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(h1_o[1]), .fwd2_hit(h2_o[1]),
    .fwd1_data(f1_o[1]), .fwd2_data(f2_o[1]),
    .count(cnt2)
  );

  // Register file as actually written by each DUT.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rw1_o[k]) rf_obs[k][rd1_o[k]] <= d1_o[k];
      if (rw2_o[k]) rf_obs[k][rd2_o[k]] <= d2_o[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return (k == 0) ? {29'd0, cnt4} : {30'd0, cnt2};
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      int sz;
      logic ew1, ew2, hit;
      logic [4:0] rs;
      logic [31:0] fd;
      string t;
      t  = $sformatf("%s/d%0d", tag, mdepth[k]);
      sz = mq[k].size();
      chk({t, ".count"}, cnt_of(k), sz);
      chk({t, ".in_ready"}, in_ready_o[k], (mdepth[k] - sz) >= 2);
      ew2 = sz >= 2;
      ew1 = (sz >= 1) && !(ew2 && (mq[k][0].rd == mq[k][1].rd));
      chk({t, ".regWrite1"}, rw1_o[k], ew1);
      chk({t, ".regWrite2"}, rw2_o[k], ew2);
      if (ew1) begin
        chk({t, ".rd1"}, rd1_o[k], mq[k][0].rd);
        chk({t, ".rd1_data"}, d1_o[k], mq[k][0].data);
      end
      if (ew2) begin
        chk({t, ".rd2"}, rd2_o[k], mq[k][1].rd);
        chk({t, ".rd2_data"}, d2_o[k], mq[k][1].data);
      end
      for (int p = 0; p < 2; p++) begin
        rs  = (p == 0) ? rs1 : rs2;
        hit = 1'b0;
        fd  = '0;
        if (rs != 5'd0) begin
          for (int i = sz - 1; i >= 0; i--) begin
            if (mq[k][i].rd == rs) begin
              hit = 1'b1;
              fd  = mq[k][i].data;
              break;
            end
          end
        end
        chk($sformatf("%s.fwd%0d_hit", t, p + 1), (p == 0) ? h1_o[k] : h2_o[k], hit);
        chk($sformatf("%s.fwd%0d_data", t, p + 1), (p == 0) ? f1_o[k] : f2_o[k], fd);
      end
    end
  endtask

  task automatic model_step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                            input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    for (int k = 0; k < 2; k++) begin
      int sz, npop;
      logic rdy;
      rf_wr_t e;
      sz   = mq[k].size();
      rdy  = (mdepth[k] - sz) >= 2;
      npop = (sz >= 2) ? 2 : sz;
      for (int j = 0; j < npop; j++) begin
        e = mq[k].pop_front();
        rf_exp[k][e.rd] = e.data;
      end
      if (rdy) begin
        if (v0 && r0 != 5'd0) mq[k].push_back('{rd: r0, data: d0});
        if (v1 && r1 != 5'd0) mq[k].push_back('{rd: r1, data: d1});
      end
    end
  endtask

  task automatic cycle(input string tag,
                       input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] s1, input logic [4:0] s2);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
    rs1 = s1; rs2 = s2;
    #1;
    check_all(tag);
    model_step(v0, r0, d0, v1, r1, d1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) rf_exp[k][r] = '0;
    reset_n = 1'b0;
    in0_valid = 0; in0_rd = 0; in0_data = 0;
    in1_valid = 0; in1_rd = 0; in1_data = 0;
    rs1 = 5'd9; rs2 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset/d%0d.count", mdepth[k]), cnt_of(k), 0);
      chk($sformatf("reset/d%0d.in_ready", mdepth[k]), in_ready_o[k], 1);
      chk($sformatf("reset/d%0d.regWrite1", mdepth[k]), rw1_o[k], 0);
      chk($sformatf("reset/d%0d.regWrite2", mdepth[k]), rw2_o[k], 0);
      chk($sformatf("reset/d%0d.rd1", mdepth[k]), rd1_o[k], 0);
      chk($sformatf("reset/d%0d.rd1_data", mdepth[k]), d1_o[k], 0);
      chk($sformatf("reset/d%0d.rd2", mdepth[k]), rd2_o[k], 0);
      chk($sformatf("reset/d%0d.rd2_data", mdepth[k]), d2_o[k], 0);
      chk($sformatf("reset/d%0d.fwd_hits", mdepth[k]), {h1_o[k], h2_o[k]}, 0);
      chk($sformatf("reset/d%0d.fwd_data", mdepth[k]), f1_o[k] | f2_o[k], 0);
    end
    reset_n = 1'b1;
    idle("idle", 2);

    cycle("pair", 1, 5, 32'hA, 1, 6, 32'hB, 0, 0);
    idle("pair_drain", 2);

    cycle("waw", 1, 7, 32'h1, 1, 7, 32'h2, 0, 0);
    idle("waw_drain", 1);
    chk("waw.rf_x7/d4", rf_obs[0][7], 32'h2);
    chk("waw.rf_x7/d2", rf_obs[1][7], 32'h2);

    cycle("x0_drop", 1, 0, 32'hFF, 1, 3, 32'hC, 0, 0);
    idle("x0_drain", 2);

    cycle("lone1", 0, 0, 0, 1, 4, 32'h44, 0, 0);
    idle("lone1_drain", 2);

    // Newly enqueued entries are not visible to forwarding until the next cycle.
    cycle("fwd_push", 1, 9, 32'h4, 1, 9, 32'h8, 9, 0);
    cycle("fwd_look", 0, 0, 0, 0, 0, 0, 9, 0);
    idle("fwd_drain", 1);

    // Held pushes: the DEPTH=2 queue must refuse the second pair.
    cycle("hold0", 1, 12, 32'h120, 1, 13, 32'h130, 12, 13);
    cycle("hold1", 1, 14, 32'h140, 1, 15, 32'h150, 14, 13);
    cycle("hold2", 1, 16, 32'h160, 1, 17, 32'h170, 16, 15);
    idle("hold_drain", 3);

    // Asynchronous reset while the ports are busy.
    cycle("mid_push", 1, 10, 32'h11, 1, 11, 32'h22, 0, 0);
    in0_valid = 0; in1_valid = 0; rs1 = 10; rs2 = 11;
    #1;
    check_all("mid_pre");
    #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mid_rst/d%0d.regWrite1", mdepth[k]), rw1_o[k], 0);
      chk($sformatf("mid_rst/d%0d.regWrite2", mdepth[k]), rw2_o[k], 0);
      chk($sformatf("mid_rst/d%0d.count", mdepth[k]), cnt_of(k), 0);
      mq[k].delete();
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle("post_rst", 1);

    for (int n = 0; n < 400; n++) begin
      cycle("rand",
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle("final_drain", 3);

    for (int k = 0; k < 2; k++)
      for (int r = 1; r < 32; r++)
        chk($sformatf("rf_order/d%0d.x%0d", mdepth[k], r), rf_obs[k][r], rf_exp[k][r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) rf_obs[k][r] = '0;
  end
endmodule
